// File: rtl/lfsr_search_ctrl.sv
// -----------------------------------------------------------------------------
// lfsr_search_ctrl
//
// Sequences the 16-bit LFSR/barrel-shifter datapath for one associative-memory
// search at a time. A request latches the key onto the datapath X input. The
// controller then pulses a clear to the LFSR and steps it until one of three
// things happens: the comparator reports a match, the step limit is reached,
// or the host aborts. It then reports hit/miss and the step index of the match.
//
// Parameters
//   KEY_W     : width of the search key / datapath X input
//   CNT_W     : width of the step counter and Step_Count
//   MAX_STEPS : enables issued before a search is declared a miss (1..2^CNT_W-1)
//   CMP_LAT   : cycles from LFSR_OUT showing a state to Compare_Found for it (>=1)
//
// Ports
//   LFSR_Clock    in   single clock, all state on the rising edge
//   Reset         in   asynchronous, active-low reset
//   Req_Valid     in   search request valid
//   Req_Ready     out  controller idle and able to accept a request
//   Req_Key       in   key for the request
//   Abort         in   terminate the current search
//   Compare_Found in   comparator match, CMP_LAT cycles after the state
//   LFSR_X        out  registered key driven to datapath X
//   LFSR_Clr      out  one-cycle clear of the LFSR register
//   LFSR_Enable   out  LFSR advance enable
//   Busy          out  high while a search is in progress
//   Done          out  one-cycle pulse when Hit/Step_Count are valid
//   Hit           out  1 = match found, 0 = miss/abort; held until next accept
//   Step_Count    out  step index of the match, or enables issued on miss/abort
// -----------------------------------------------------------------------------
module lfsr_search_ctrl #(
  parameter int KEY_W     = 4,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 65535,
  parameter int CMP_LAT   = 1
) (
  input  logic             LFSR_Clock,
  input  logic             Reset,
  input  logic             Req_Valid,
  output logic             Req_Ready,
  input  logic [KEY_W-1:0] Req_Key,
  input  logic             Abort,
  input  logic             Compare_Found,
  output logic [KEY_W-1:0] LFSR_X,
  output logic             LFSR_Clr,
  output logic             LFSR_Enable,
  output logic             Busy,
  output logic             Done,
  output logic             Hit,
  output logic [CNT_W-1:0] Step_Count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam int               FL_W       = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(MAX_STEPS - 1);
  localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(CMP_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] en_cnt;     // enables already applied = state index on LFSR_OUT
  logic [FL_W-1:0]  flush_cnt;

  // Tag pipe: one entry per cycle, tracking which step index the comparator
  // is currently judging. Entry CMP_LAT-1 lines up with Compare_Found.
  logic [CMP_LAT-1:0] tag_valid;
  logic [CNT_W-1:0]   tag_idx [CMP_LAT];

  logic             accept;
  logic             in_search;
  logic             hit_now;
  logic             fin;
  logic             fin_hit;
  logic [CNT_W-1:0] fin_step;

  assign accept    = Req_Valid & Req_Ready;
  assign in_search = (state == S_RUN) || (state == S_FLUSH);
  // A Found only counts when the state it refers to was produced by a real
  // step of this search; anything else is pre-clear or post-stop garbage.
  assign hit_now   = in_search & tag_valid[CMP_LAT-1] & Compare_Found;

  // Termination decision. Priority: valid hit, then abort, then flush timeout.
  // A hit in the last RUN cycle also beats the terminal count, because the
  // RUN branch below is only taken when fin is low.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    fin      = 1'b0;
    fin_hit  = 1'b0;
    fin_step = en_cnt;
    if (hit_now) begin
      fin      = 1'b1;
      fin_hit  = 1'b1;
      fin_step = tag_idx[CMP_LAT-1];
    end else if (Abort && (state == S_INIT || in_search)) begin
      fin = 1'b1;
    end else if (state == S_FLUSH && flush_cnt == FLUSH_LAST) begin
      fin = 1'b1;
    end
  end

  // Tag pipe shift. A new search empties it on accept so stale tags from the
  // previous search can never line up with the new one.
  always_ff @(posedge LFSR_Clock or negedge Reset) begin
    if (!Reset) begin
      // NOTE: the tag array is tiny control state, so it is reset with
      // everything else; a wide data memory would normally be left unreset.
      tag_valid <= '0;
      for (int k = 0; k < CMP_LAT; k++) tag_idx[k] <= '0;
    end else begin
      for (int k = CMP_LAT - 1; k >= 1; k--) begin
        tag_valid[k] <= tag_valid[k-1] & ~accept;
        tag_idx[k]   <= tag_idx[k-1];
      end
      tag_valid[0] <= (state == S_RUN) & ~accept;
      tag_idx[0]   <= en_cnt;
    end
  end

  // Main sequencer; all outputs are registered alongside the state.
  always_ff @(posedge LFSR_Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= S_IDLE;
      Req_Ready   <= 1'b1;
      LFSR_X      <= '0;
      LFSR_Clr    <= 1'b0;
      LFSR_Enable <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Hit         <= 1'b0;
      Step_Count  <= '0;
      en_cnt      <= '0;
      flush_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // updates from the values all of them held before this edge.
      LFSR_Clr <= 1'b0;
      Done     <= 1'b0;
      if (fin) begin
        LFSR_Enable <= 1'b0;
        Busy        <= 1'b0;
        Done        <= 1'b1;
        Hit         <= fin_hit;
        Step_Count  <= fin_step;
        state       <= S_DONE;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              LFSR_X     <= Req_Key;
              Hit        <= 1'b0;
              Step_Count <= '0;
              en_cnt     <= '0;
              LFSR_Clr   <= 1'b1;
              Busy       <= 1'b1;
              Req_Ready  <= 1'b0;
              state      <= S_INIT;
            end
          end
          S_INIT: begin
            en_cnt      <= '0;
            LFSR_Enable <= 1'b1;
            state       <= S_RUN;
          end
          S_RUN: begin
            en_cnt <= en_cnt + 1'b1;
            if (en_cnt == LAST_IDX) begin
              LFSR_Enable <= 1'b0;
              flush_cnt   <= '0;
              state       <= S_FLUSH;
            end
          end
          // Wait for the comparator to judge the states still in flight.
          S_FLUSH: flush_cnt <= flush_cnt + 1'b1;
          S_DONE: begin
            Req_Ready <= 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lfsr_search_ctrl
//
// Self-checking bench for lfsr_search_ctrl. A small environment model plays the
// LFSR and comparator. It tracks the LFSR state index from Clr/Enable and
// raises Compare_Found CMP_LAT cycles after the state that matches the target.
// Optionally it also injects spurious Found pulses where no real step is being
// judged. Expected results come from closed-form rules on the step/abort
// timeline.
// -----------------------------------------------------------------------------
module tb_lfsr_search_ctrl;

  localparam int KEY_W = 4;
  localparam int CNT_W = 8;
  localparam int MAX   = 10;
  localparam int LAT   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [KEY_W-1:0] req_key;
  logic             abort;
  logic             compare_found;
  logic [KEY_W-1:0] lfsr_x;
  logic             lfsr_clr;
  logic             lfsr_enable;
  logic             busy;
  logic             done;
  logic             hit;
  logic [CNT_W-1:0] step_count;

  always #5 clk = ~clk;

  lfsr_search_ctrl #(
    .KEY_W    (KEY_W),
    .CNT_W    (CNT_W),
    .MAX_STEPS(MAX),
    .CMP_LAT  (LAT)
  ) dut (
    .LFSR_Clock   (clk),
    .Reset        (rst_n),
    .Req_Valid    (req_valid),
    .Req_Ready    (req_ready),
    .Req_Key      (req_key),
    .Abort        (abort),
    .Compare_Found(compare_found),
    .LFSR_X       (lfsr_x),
    .LFSR_Clr     (lfsr_clr),
    .LFSR_Enable  (lfsr_enable),
    .Busy         (busy),
    .Done         (done),
    .Hit          (hit),
    .Step_Count   (step_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- environment: LFSR + comparator ----------------
  int lfsr_idx   = 0;
  bit lfsr_known = 1'b0;
  int target     = -1;
  bit noise_en   = 1'b0;
  int hq_state[$];
  bit hq_known[$];
  bit hq_en[$];

  // Called once per falling edge: decides Found for this cycle from the state
  // shown LAT cycles ago, then advances the LFSR index for the next cycle.
  task automatic env_tick();
    int st;
    bit kn;
    bit en;
    hq_state.push_back(lfsr_idx);
    hq_known.push_back(lfsr_known);
    hq_en.push_back(lfsr_enable === 1'b1);
    compare_found = 1'b0;
    if (hq_state.size() > LAT) begin
      st = hq_state.pop_front();
      kn = hq_known.pop_front();
      en = hq_en.pop_front();
      compare_found = (kn && target >= 0 && st == target) ||
                      (noise_en && !en && $urandom_range(0, 1) == 1);
    end
    if (lfsr_clr === 1'b1) begin
      lfsr_idx   = 0;
      lfsr_known = 1'b1;
    end else if (lfsr_enable === 1'b1) begin
      lfsr_idx++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    env_tick();
  endtask

  // ---------------- one search ----------------
  // tgt     : step index whose state matches (-1 = never)
  // ab      : RUN-relative cycle to pulse Abort (-1 = INIT, < -1 = none)
  // nz      : enable spurious Found injection
  // early   : cycle at which the next request is raised while still busy
  // rst_at  : cycle at which reset is asserted mid-search (< -1 = none)
  task automatic search(input int tgt, input int ab, input bit nz, input int early,
                        input int rst_at);
    logic [KEY_W-1:0] key;
    int e_to, e_end, e_step, e_en, e_hit;
    int rc, en_cnt, clr_cnt, bad_busy, bad_x, bad_clr, wait_n, done_rc;
    logic [31:0] got_hit, got_step, got_idle;

    if (req_valid !== 1'b1) begin
      req_key   = KEY_W'($urandom_range(0, (1 << KEY_W) - 1));
      req_valid = 1'b1;
    end
    key      = req_key;
    target   = tgt;
    noise_en = nz;

    wait_n = 0;
    while (req_ready !== 1'b1 && wait_n < 20) begin
      tick();
      wait_n++;
    end
    check("accept_ready", req_ready, 1);
    tick();                      // INIT cycle
    req_valid = 1'b0;

    // Expected outcome on the RUN-relative timeline.
    e_to = MAX + LAT - 1;
    if (tgt >= 0 && tgt < MAX && (ab < -1 || tgt + LAT <= ab)) begin
      e_end = tgt + LAT; e_hit = 1; e_step = tgt;
    end else if (ab >= -1 && ab <= e_to) begin
      e_end = ab; e_hit = 0; e_step = (ab < 0) ? 0 : ((ab < MAX) ? ab : MAX);
    end else begin
      e_end = e_to; e_hit = 0; e_step = MAX;
    end
    e_en = (e_end + 1 < MAX) ? e_end + 1 : MAX;

    rc = -1; en_cnt = 0; clr_cnt = 0; bad_busy = 0; bad_x = 0; bad_clr = 0;
    done_rc = -99; got_hit = 'x; got_step = 'x; got_idle = 'x;
    for (int guard = 0; guard < MAX + LAT + 8; guard++) begin
      if (rc == rst_at) begin
        rst_n = 1'b0;
        abort = 1'b0;
        #1;
        check("rst_outputs", {lfsr_enable, req_ready, busy, done, hit}, 5'b01000);
        tick();
        rst_n = 1'b1;
        bad_busy = 0;
        for (int i = 0; i < 4; i++) begin
          if (done !== 1'b0 || req_ready !== 1'b1 || lfsr_enable !== 1'b0) bad_busy++;
          tick();
        end
        check("rst_quiet", bad_busy, 0);
        return;
      end
      if (lfsr_enable === 1'b1) en_cnt++;
      if (lfsr_clr === 1'b1) begin
        clr_cnt++;
        if (rc != -1) bad_clr++;
      end
      if (lfsr_x !== key) bad_x++;
      if (done === 1'b1) begin
        done_rc  = rc;
        got_hit  = hit;
        got_step = step_count;
        got_idle = {busy, req_ready};
        abort    = (rc == ab);   // abort in DONE must be ignored
        break;
      end
      if (busy !== 1'b1 || req_ready !== 1'b0) bad_busy++;
      abort = (rc == ab);
      if (rc == early) begin
        req_valid = 1'b1;
        req_key   = ~key;
      end
      tick();
      rc++;
    end

    check("done_cycle", done_rc, e_end + 1);
    check("hit", got_hit, e_hit);
    check("step_count", got_step, e_step);
    check("enables", en_cnt, e_en);
    check("clr_once", clr_cnt + bad_clr * 16, 1);
    check("busy_run", bad_busy, 0);
    check("key_held", bad_x, 0);
    check("done_idle", got_idle, 0);

    tick();
    abort = 1'b0;
    check("done_pulse", {done, req_ready}, 2'b01);
    check("hold", {hit, step_count}, {e_hit[0], e_step[CNT_W-1:0]});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_key = '0; abort = 1'b0; compare_found = 1'b0;
    tick();
    tick();
    check("reset_state",
          {req_ready, lfsr_x, lfsr_clr, lfsr_enable, busy, done, hit, step_count},
          {1'b1, {KEY_W{1'b0}}, 5'b00000, {CNT_W{1'b0}}});
    rst_n = 1'b1;
    tick();

    search(5, -5, 0, -99, -99);           // plain hit
    search(-1, -5, 0, -99, -99);          // never match -> MAX enables, miss
    search(MAX - 1, -5, 0, -99, -99);     // last step found during FLUSH
    search(0, LAT, 0, -99, -99);          // hit and abort in the same cycle
    search(-1, 3, 0, -99, -99);           // abort alone on 4th RUN cycle
    search(-1, -1, 0, -99, -99);          // abort in INIT
    search(MAX, -5, 0, -99, -99);         // state MAX is never judged
    search(-1, MAX + 1, 0, -99, -99);     // abort during FLUSH
    search(4, -5, 1, 2, -99);             // request held while busy, noise
    search(6, -5, 1, -99, -99);           // the held request runs normally
    search(3, -5, 0, -99, 4);             // reset mid-search
    search(2, -5, 0, -99, -99);           // normal search after reset

    repeat (40) begin
      int tgt, ab, early;
      bit nz;
      tgt   = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, MAX + 1));
      ab    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, MAX + LAT)) - 1 : -5;
      nz    = 1'($urandom_range(0, 1));
      early = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAX)) : -99;
      search(tgt, ab, nz, early, -99);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
